serial_rx_fifo: RTL and testbench
=================================

// Module: serial_rx_fifo
// PURPOSE
//  Board-side 8N1 UART receiver with a show-ahead receive FIFO; the counterpart to the TxD path of comp.
//  Sits between the board RxD pin and a polling consumer (debug port, loader or test logic) in the board top.
//  Synchronises RxD, recovers bytes by mid-bit sampling, buffers them and flags framing/overrun errors.
// PARAMETERS
//  CLKS_PER_BIT  217  clk cycles per bit (25 MHz / 115200); legal >= 4
//  FIFO_AW       4    FIFO address width; depth = 2**FIFO_AW
// PORTS
//  clk        in   1          system clock (selected_clk domain)
//  reset      in   1          asynchronous, active-high reset
//  RxD        in   1          serial input, idle high, asynchronous to clk
//  rd         in   1          pop request; honoured only when valid=1
//  err_clr    in   1          clears sticky error flags
//  dout       out  8          FIFO head byte (show-ahead)
//  valid      out  1          FIFO not empty
//  count      out  FIFO_AW+1  bytes held, 0..2**FIFO_AW
//  frame_err  out  1          sticky: stop bit sampled 0
//  overrun    out  1          sticky: byte dropped, FIFO full
// BEHAVIOUR
//  Reset: state=IDLE; sync flops=1; bit ctr, shift reg, FIFO ptrs=0; valid=0, count=0, frame_err=0,
//   overrun=0, dout=mem[0] (don't-care while valid=0). Reset mid-frame aborts it; partial byte discarded.
//  RxD passes a 2-flop synchroniser (rxs); all decisions use rxs. Input-to-rxs latency: 2 clk.
//  Bit timer: cnt counts 0..CLKS_PER_BIT-1, cleared on every state change.
//  FSM:
//   IDLE  : rxs==0 -> START.
//   START : at cnt==CLKS_PER_BIT/2-1 sample rxs; 0 -> DATA (mid-bit alignment), 1 -> IDLE (glitch, no flags).
//   DATA  : at cnt==CLKS_PER_BIT-1 sample rxs into shift reg, LSB first; after 8th sample -> STOP.
//   STOP  : at cnt==CLKS_PER_BIT-1 sample rxs; 1 -> push byte, -> IDLE;
//           0 -> set frame_err, drop byte, -> BREAK.
//   BREAK : wait for rxs==1 -> IDLE (line break/held low never re-triggers START).
//  Push: issued in the stop-sample cycle; valid/count/dout update on the next clk edge (1-cycle latency).
//  FIFO: dout=mem[rd_ptr] combinationally; pop when rd&&valid advances rd_ptr at clk edge.
//   rd while empty: ignored, no pointer/count change.
//   Push when full and no pop: byte dropped, overrun set, contents untouched.
//   Push when full with pop same cycle: both succeed, count stays at max, overrun not set.
//   Push and pop same cycle otherwise: count unchanged.
//   Pointers wrap modulo 2**FIFO_AW; count is the true occupancy (FIFO_AW+1 bits).
//  Flags: sticky until err_clr; a set event in the same cycle as err_clr wins (flag stays 1).
//  No parity, 1 stop bit only; stop-sample cycle to next START detection is >=1 clk (back-to-back frames ok).
// TESTING (CLKS_PER_BIT=8, FIFO_AW=2 unless noted)
//  1 Drive frame 0x A5 (start,1,0,1,0,0,1,0,1,stop) at 8 clk/bit -> valid=1, dout=8'hA5, count=1,
//     flags 0; rd pulse -> valid=0, count=0.
//  2 Low glitch of 2 clk on idle RxD -> FSM returns to IDLE, count=0, no flags.
//  3 Frame 0x3C with stop bit 0 then RxD low 40 clk -> frame_err=1, count=0; RxD high then frame 0x11
//     -> dout=8'h11; err_clr -> frame_err=0.
//  4 Send 5 bytes 0x01..0x05 with no reads -> count=4, overrun=1, pops return 01,02,03,04 then valid=0.
//  5 FIFO full (01..04), hold rd=1 in the push cycle of 0x05 -> count stays 4, overrun=0,
//     sequence 02,03,04,05.
//  6 Assert reset mid-DATA of a frame -> all outputs at reset values; next full frame 0x7E received
//     correctly; also check rd on empty leaves count=0.

Source files
------------

// File: rtl/serial_rx_fifo_if.sv
// Consumer-side bus of the serial receive FIFO: pop/clear requests in, head byte and status out.
interface serial_rx_fifo_if #(
  parameter int FIFO_AW = 4
);
  logic             rd;
  logic             err_clr;
  logic [7:0]       dout;
  logic             valid;
  logic [FIFO_AW:0] count;
  logic             frame_err;
  logic             overrun;

  modport master (
    output rd, err_clr,
    input  dout, valid, count, frame_err, overrun
  );

  modport slave (
    input  rd, err_clr,
    output dout, valid, count, frame_err, overrun
  );
endinterface

// File: rtl/serial_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a show-ahead FIFO; sticky framing/overrun flags.
module serial_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_AW      = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           RxD,
  serial_rx_fifo_if.slave bus
);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [CW-1:0]    CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FIFO_AW:0] OCC_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t             state_q, state_d;
  logic               rx_meta, rxs;
  logic [CW-1:0]      cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift_q;
  logic               shift_en, push, frame_set;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   occ;
  logic [7:0]         mem [DEPTH];
  logic               full, do_pop, do_push, overrun_set;
  logic               frame_err_q, overrun_q;

  // Two-flop synchroniser; idle level is high so a reset never fakes a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || cnt == CNT_LAST) cnt <= '0;
      else                                       cnt <= cnt + CW'(1);
      if (state_d != state_q) bit_idx <= '0;
      else if (shift_en)      bit_idx <= bit_idx + 3'd1;
      if (shift_en) shift_q <= {rxs, shift_q[7:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      IDLE:  if (!rxs) state_d = START;
      START: if (cnt == CNT_MID) state_d = rxs ? IDLE : DATA;
      DATA:  if (cnt == CNT_LAST) begin
               shift_en = 1'b1;
               if (bit_idx == 3'd7) state_d = STOP;
             end
      STOP:  if (cnt == CNT_LAST) begin
               if (rxs) begin
                 push    = 1'b1;
                 state_d = IDLE;
               end else begin
                 frame_set = 1'b1;
                 state_d   = BREAK;
               end
             end
      BREAK: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
  assign full        = (occ == OCC_FULL);
  assign do_pop      = bus.rd && (occ != '0);
  assign do_push     = push && (!full || do_pop);
  assign overrun_set = push && full && !do_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (do_push && !do_pop)      occ <= occ + (FIFO_AW + 1)'(1);
      else if (do_pop && !do_push) occ <= occ - (FIFO_AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift_q;
  end

  // Set events take priority over err_clr so a coincident error is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (frame_set)        frame_err_q <= 1'b1;
      else if (bus.err_clr) frame_err_q <= 1'b0;
      if (overrun_set)      overrun_q   <= 1'b1;
      else if (bus.err_clr) overrun_q   <= 1'b0;
    end
  end

  assign bus.dout      = mem[rd_ptr];
  assign bus.valid     = (occ != '0);
  assign bus.count     = occ;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed bench for serial_rx_fifo at 8 clk/bit, depth 4, with a queue of expected bytes.
module tb_serial_rx_fifo;
  localparam int CPB = 8;
  localparam int AW  = 2;

  logic clk = 1'b0;
  logic reset;
  logic RxD;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] exp_q [$];

  serial_rx_fifo_if #(.FIFO_AW(AW)) bus ();

  serial_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .RxD   (RxD),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=%0h expected=<no byte queued>", tag, bus.dout);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'd0, bus.dout}, {24'd0, e});
    end
  endtask

  // Bit i is driven right after posedge 8*i; with 2-flop sync the stop sample lands at posedge 79.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic rd_at_push);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RxD = bits[i];
      for (int c = 0; c < CPB; c++) begin
        @(posedge clk);
        #1;
        if (rd_at_push && i == 9 && c == 5) begin
          bus.rd = 1'b1;
          @(negedge clk);
          check("full_before_push", {29'd0, bus.count}, 32'd4);
          check_head("pop_in_push_cycle");
        end
        if (rd_at_push && i == 9 && c == 6) bus.rd = 1'b0;
      end
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus.valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
    check_head(tag);
    @(posedge clk);
    #1 bus.rd = 1'b1;
    @(posedge clk);
    #1 bus.rd = 1'b0;
  endtask

  task automatic pulse_err_clr();
    bus.err_clr = 1'b1;
    idle(1);
    bus.err_clr = 1'b0;
  endtask

  task automatic check_status(input string tag, input int cnt, input logic fe, input logic ov);
    @(negedge clk);
    check({tag, "_count"}, {29'd0, bus.count}, 32'(cnt));
    check({tag, "_valid"}, {31'd0, bus.valid}, {31'd0, cnt != 0});
    check({tag, "_frame_err"}, {31'd0, bus.frame_err}, {31'd0, fe});
    check({tag, "_overrun"}, {31'd0, bus.overrun}, {31'd0, ov});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    RxD         = 1'b1;
    bus.rd      = 1'b0;
    bus.err_clr = 1'b0;
    idle(3);
    check_status("reset", 0, 1'b0, 1'b0);
    reset = 1'b0;
    idle(4);

    // 1: single byte, then pop
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_valid("t1_wait", 20);
    check_status("t1_stored", 1, 1'b0, 1'b0);
    pop_check("t1_pop");
    check_status("t1_empty", 0, 1'b0, 1'b0);

    // 2: short low glitch is rejected at mid-start
    RxD = 1'b0;
    idle(2);
    RxD = 1'b1;
    idle(20);
    check_status("t2_glitch", 0, 1'b0, 1'b0);

    // 3: framing error, held-low break, recovery
    send_frame(8'h3C, 1'b0, 1'b0);
    RxD = 1'b0;
    idle(40);
    check_status("t3_break", 0, 1'b1, 1'b0);
    RxD = 1'b1;
    idle(10);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    idle(2);
    check_status("t3_after", 1, 1'b1, 1'b0);
    pop_check("t3_pop");
    pulse_err_clr();
    check_status("t3_clr", 0, 1'b0, 1'b0);

    // 4: overrun on fifth byte
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b1, 1'b0);
    end
    idle(2);
    check_status("t4_full", 4, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) pop_check("t4_pop");
    check_status("t4_drained", 0, 1'b0, 1'b1);
    pulse_err_clr();
    check_status("t4_clr", 0, 1'b0, 1'b0);

    // 5: push into full FIFO with simultaneous pop
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b1, 1'b0);
    end
    exp_q.push_back(8'h05);
    send_frame(8'h05, 1'b1, 1'b1);
    idle(2);
    check_status("t5_full", 4, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) pop_check("t5_pop");
    check_status("t5_drained", 0, 1'b0, 1'b0);

    // 6: reset in the middle of DATA, then a clean frame and rd on empty
    send_frame(8'h55, 1'b1, 1'b0);
    idle(2);
    check_status("t6_pre", 1, 1'b0, 1'b0);
    RxD = 1'b0;
    idle(CPB);
    RxD = 1'b1;
    idle(CPB);
    RxD = 1'b0;
    idle(CPB);
    reset = 1'b1;
    #1;
    check("t6_async_count", {29'd0, bus.count}, 32'd0);
    check("t6_async_valid", {31'd0, bus.valid}, 32'd0);
    RxD = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(5);
    check_status("t6_reset", 0, 1'b0, 1'b0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0);
    wait_valid("t6_wait", 20);
    pop_check("t6_pop");
    bus.rd = 1'b1;
    idle(2);
    bus.rd = 1'b0;
    check_status("t6_rd_empty", 0, 1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
